// File: rtl/uop_sequencer.sv
// -----------------------------------------------------------------------------
// uop_sequencer
// Microcode sequencer. It walks a registered microcode ROM from address 0 and
// issues one micro-operation at a time to a datapath. It stops on an RDY word,
// on an illegal word, or when the last ROM address is passed.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ena         start pulse, sampled only while idle
//   rdy         high while idle or finished, low while a program runs
//   err         last run ended on an illegal opcode, an illegal exec field or
//               an address overflow; held until the next start
//   rom_addr    microcode ROM address
//   rom_data    ROM word, valid one cycle after rom_addr
//   uop_ena     one-cycle issue pulse
//   uop_opcode  issued opcode      (rom_data[19:16])
//   uop_src_a   operand A select   (rom_data[15:11])
//   uop_src_b   operand B select   (rom_data[10:6])
//   uop_dst     destination select (rom_data[5:2])
//   uop_done    datapath completion pulse for the outstanding uop
//   uop_cmp_eq  compare result, valid together with uop_done of a CMP
// -----------------------------------------------------------------------------
module uop_sequencer #(
    parameter int ADDR_W = 6,
    parameter int UOP_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic              rdy,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [UOP_W-1:0]  rom_data,
    output logic              uop_ena,
    output logic [3:0]        uop_opcode,
    output logic [4:0]        uop_src_a,
    output logic [4:0]        uop_src_b,
    output logic [3:0]        uop_dst,
    input  logic              uop_done,
    input  logic              uop_cmp_eq
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]        OP_RDY    = 4'd0;
    localparam logic [3:0]        OP_CMP    = 4'd5;
    localparam logic [1:0]        EX_ALWAYS = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Opcodes RDY..CMP are defined; everything above CMP is illegal.
    function automatic logic opcode_legal(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

    // Exec fields 2'b10 and 2'b11 are reserved.
    function automatic logic exec_legal(input logic [1:0] ex);
        return (ex[1] == 1'b0);
    endfunction

    state_t            state_r,    state_s;
    logic [ADDR_W-1:0] rom_addr_r, rom_addr_s;
    logic              rdy_r,      rdy_s;
    logic              err_r,      err_s;
    logic              uop_ena_r,  uop_ena_s;
    logic [3:0]        opcode_r,   opcode_s;
    logic [4:0]        src_a_r,    src_a_s;
    logic [4:0]        src_b_r,    src_b_s;
    logic [3:0]        dst_r,      dst_s;
    logic              cmp_flag_r, cmp_flag_s;

    logic [3:0]        dec_op_s;
    logic [1:0]        dec_ex_s;

    assign dec_op_s = rom_data[19:16];
    assign dec_ex_s = rom_data[1:0];

    // Next-state, next-output and datapath-register update logic.
    always_comb begin
        state_s    = state_r;
        rom_addr_s = rom_addr_r;
        rdy_s      = rdy_r;
        err_s      = err_r;
        uop_ena_s  = 1'b0;
        opcode_s   = opcode_r;
        src_a_s    = src_a_r;
        src_b_s    = src_b_r;
        dst_s      = dst_r;
        cmp_flag_s = cmp_flag_r;

        case (state_r)
            ST_IDLE: begin
                rdy_s = 1'b1;
                if (ena) begin
                    state_s    = ST_FETCH;
                    rom_addr_s = ADDR_ZERO;
                    cmp_flag_s = 1'b0;
                    err_s      = 1'b0;
                    rdy_s      = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                state_s = ST_DECODE;
            end

            ST_DECODE: begin
                if (dec_op_s == OP_RDY) begin
                    state_s = ST_DONE;
                    rdy_s   = 1'b1;
                end else if (!opcode_legal(dec_op_s) || !exec_legal(dec_ex_s)) begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                    rdy_s   = 1'b1;
                end else if ((dec_ex_s == EX_ALWAYS) || cmp_flag_r) begin
                    uop_ena_s = 1'b1;
                    opcode_s  = dec_op_s;
                    src_a_s   = rom_data[15:11];
                    src_b_s   = rom_data[10:6];
                    dst_s     = rom_data[5:2];
                    state_s   = ST_WAIT;
                end else if (rom_addr_r == ADDR_LAST) begin
                    // Skipped the last word without meeting RDY: never wrap.
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                    rdy_s   = 1'b1;
                end else begin
                    rom_addr_s = rom_addr_r + ADDR_ONE;
                    state_s    = ST_FETCH;
                end
            end

            ST_WAIT: begin
                // A done pulse coinciding with the issue pulse belongs to no uop.
                if (uop_done && !uop_ena_r) begin
                    if (opcode_r == OP_CMP) begin
                        cmp_flag_s = uop_cmp_eq;
                    end else begin
                        cmp_flag_s = cmp_flag_r;
                    end
                    if (rom_addr_r == ADDR_LAST) begin
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                        rdy_s   = 1'b1;
                    end else begin
                        rom_addr_s = rom_addr_r + ADDR_ONE;
                        state_s    = ST_FETCH;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                rdy_s   = 1'b1;
            end

            default: begin
                state_s = ST_IDLE;
                rdy_s   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rom_addr_r <= ADDR_ZERO;
            rdy_r      <= 1'b1;
            err_r      <= 1'b0;
            uop_ena_r  <= 1'b0;
            opcode_r   <= 4'd0;
            src_a_r    <= 5'd0;
            src_b_r    <= 5'd0;
            dst_r      <= 4'd0;
            cmp_flag_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rom_addr_r <= rom_addr_s;
            rdy_r      <= rdy_s;
            err_r      <= err_s;
            uop_ena_r  <= uop_ena_s;
            opcode_r   <= opcode_s;
            src_a_r    <= src_a_s;
            src_b_r    <= src_b_s;
            dst_r      <= dst_s;
            cmp_flag_r <= cmp_flag_s;
        end
    end

    assign rdy        = rdy_r;
    assign err        = err_r;
    assign rom_addr   = rom_addr_r;
    assign uop_ena    = uop_ena_r;
    assign uop_opcode = opcode_r;
    assign uop_src_a  = src_a_r;
    assign uop_src_b  = src_b_r;
    assign uop_dst    = dst_r;

endmodule
